pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 144 ++++++++++++++
 tb/tb_pattern_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
//==============================================================================
// Module  : pattern_gen
// Purpose : Serialises the low len bits of a latched pattern MSB first,
//           repeated rep+1 times back to back, then pulses done.
// Revision: 1.0
//==============================================================================
`default_nettype none

module pattern_gen #(
  parameter int W  = 8,
  parameter int LW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  pat,
  input  logic [LW-1:0] len,
  input  logic [CW-1:0] rep,
  output logic          out,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0] C_W_LEN = LW'(W);

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  r_pat;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [CW-1:0] r_pass;
  logic          r_out;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_wrap;
  logic          w_finish;
  logic [LW-1:0] w_eff_len;
  logic [W-1:0]  w_src;
  logic [LW-1:0] w_sel;
  logic [W-1:0]  w_shifted;

  // Over-long requests are silently clamped to the pattern width.
  assign w_eff_len = (len > C_W_LEN) ? C_W_LEN : len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    w_wrap   = 1'b0;
    w_finish = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d  = SEND;
          w_accept = 1'b1;
        end
      end
      SEND: begin
        if (r_idx == '0) begin
          if (r_pass == '0) begin
            state_d  = DONE;
            w_finish = 1'b1;
          end else begin
            w_wrap = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pick the bit that goes on the wire in the coming cycle.
  always_comb begin
    w_src = r_pat;
    w_sel = r_idx - LW'(1);
    if (w_accept) begin
      w_src = pat;
      w_sel = w_eff_len - LW'(1);
    end else if (w_wrap) begin
      w_sel = r_len - LW'(1);
    end
  end

  assign w_shifted = w_src >> w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_pass      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_pat       <= pat;
      r_len       <= w_eff_len;
      r_idx       <= w_eff_len - LW'(1);
      r_pass      <= rep;
      r_out       <= w_shifted[0];
      r_out_valid <= 1'b1;
    end else if (state_q == SEND) begin
      if (w_finish) begin
        r_out       <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (w_wrap) begin
        r_pass <= r_pass - CW'(1);
        r_idx  <= r_len - LW'(1);
        r_out  <= w_shifted[0];
      end else begin
        r_idx <= r_idx - LW'(1);
        r_out <= w_shifted[0];
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_pattern_gen.sv
//==============================================================================
// Module  : tb_pattern_gen
// Purpose : Directed self-checking bench for pattern_gen.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pat;
  logic [3:0] len;
  logic [3:0] rep;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;

  pattern_gen #(.W(8), .LW(4), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pat       (pat),
    .len       (len),
    .rep       (rep),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, {31'd0, out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pat   = p;
    len   = l;
    rep   = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Checks n bits (MSB of the n-bit field first), then the done cycle and
  // the return to idle. At iteration poke_at a competing start is raised.
  task automatic expect_stream(input string tag, input logic [63:0] bits, input int n,
                               input int poke_at);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_bit"}, {31'd0, out}, {31'd0, bits[n-1-i]});
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      // Inputs changing after acceptance must not disturb the transfer.
      pat = ~pat;
      len = 4'd3;
      rep = 4'd7;
      start = (i == poke_at);
      step();
    end
    start = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_done_out"}, {31'd0, out}, 32'd0);
    step();
    chk_idle({tag, "_after"});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    pat   = 8'h00;
    len   = 4'd0;
    rep   = 4'd0;
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;

    // Two passes of a 4-bit field.
    launch(8'h0B, 4'd4, 4'd1);
    expect_stream("s0b", 64'hBB, 8, -1);

    // Full-width single pass, started right after the previous done.
    launch(8'hA5, 4'd8, 4'd0);
    expect_stream("sa5", 64'hA5, 8, -1);

    // Zero length is ignored even with start held.
    pat   = 8'hFF;
    len   = 4'd0;
    rep   = 4'd2;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("len0");
    end
    start = 1'b0;

    // A start mid-transfer is neither queued nor a restart.
    launch(8'h96, 4'd8, 4'd0);
    expect_stream("midstart", 64'h96, 8, 3);
    step();
    chk_idle("midstart_noq");

    // Asynchronous abort during the third bit.
    launch(8'h0B, 4'd4, 4'd0);
    chk("abort_b1", {31'd0, out}, 32'd1);
    step();
    chk("abort_b2", {31'd0, out}, 32'd0);
    step();
    chk("abort_b3", {31'd0, out}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("abort_now");
    step();
    chk_idle("abort_held");
    rst = 1'b0;
    launch(8'h0D, 4'd4, 4'd0);
    expect_stream("postrst", 64'hD, 4, -1);

    // Over-long length clamps to 8.
    launch(8'hF0, 4'd12, 4'd0);
    expect_stream("clamp", 64'hF0, 8, -1);

    // Maximum repeat count: 16 passes of "10".
    launch(8'h02, 4'd2, 4'd15);
    expect_stream("repmax", 64'hAAAAAAAA, 32, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
